// File: rtl/imm_extend_pipe.sv
// Immediate-extension unit (sign/zero/upper/branch) feeding a 2-entry valid/ready skid buffer.
// Optional statistics counters are enabled by defining IMM_EXTEND_STATS_EN.
module imm_extend_pipe #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int BR_SHIFT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_imm,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [1:0]           out_mode
`ifdef IMM_EXTEND_STATS_EN
  ,
  output logic [31:0]          xfer_count,
  output logic [31:0]          stall_count
`endif
);

  generate
    if (IN_WIDTH < 1) begin : g_bad_in_width
      $error("imm_extend_pipe: IN_WIDTH must be >= 1");
    end
    if (OUT_WIDTH < IN_WIDTH + 2) begin : g_bad_out_width
      $error("imm_extend_pipe: OUT_WIDTH must be >= IN_WIDTH+2");
    end
    if (BR_SHIFT < 0 || BR_SHIFT > OUT_WIDTH - IN_WIDTH) begin : g_bad_shift
      $error("imm_extend_pipe: BR_SHIFT must be in 0..OUT_WIDTH-IN_WIDTH");
    end
  endgenerate

  localparam int EXT_W = OUT_WIDTH - IN_WIDTH;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b10
  } state_t;

  function automatic logic [OUT_WIDTH-1:0] f_extend(
    input logic [IN_WIDTH-1:0] imm,
    input logic [1:0]          mode
  );
    logic signed [OUT_WIDTH-1:0] sx;
    logic        [OUT_WIDTH-1:0] res;
    sx = {{EXT_W{imm[IN_WIDTH-1]}}, imm};
    case (mode)
      2'b00:   res = sx;
      2'b01:   res = {{EXT_W{1'b0}}, imm};
      2'b10:   res = {imm, {EXT_W{1'b0}}};
      default: res = sx <<< BR_SHIFT;
    endcase
    return res;
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_load_head;
  logic                   w_head_from_skid;
  logic                   w_load_skid;
  logic [OUT_WIDTH-1:0]   w_ext_p0;
  logic [OUT_WIDTH-1:0]   r_head_data_p1;
  logic [1:0]             r_head_mode_p1;
  logic [OUT_WIDTH-1:0]   r_skid_data_p1;
  logic [1:0]             r_skid_mode_p1;

  assign in_ready  = (r_state != S_TWO);
  assign out_valid = (r_state != S_EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Stage p0: extension is purely combinational on the incoming immediate
  assign w_ext_p0 = f_extend(in_imm, in_mode);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_head_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            w_state_nxt = S_ONE;
            w_load_head = 1'b1;
          end
        end
        S_ONE: begin
          if (w_push && !w_pop) begin
            w_state_nxt = S_TWO;
            w_load_skid = 1'b1;
          end else if (w_pop && !w_push) begin
            w_state_nxt = S_EMPTY;
          end else if (w_push && w_pop) begin
            w_load_head = 1'b1;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            w_state_nxt      = S_ONE;
            w_head_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // Stage p1: head feeds the outputs directly; skid absorbs one entry of back-pressure
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head_data_p1 <= '0;
      r_head_mode_p1 <= 2'b00;
      r_skid_data_p1 <= '0;
      r_skid_mode_p1 <= 2'b00;
    end else begin
      if (w_load_head) begin
        r_head_data_p1 <= w_ext_p0;
        r_head_mode_p1 <= in_mode;
      end else if (w_head_from_skid) begin
        r_head_data_p1 <= r_skid_data_p1;
        r_head_mode_p1 <= r_skid_mode_p1;
      end
      if (w_load_skid) begin
        r_skid_data_p1 <= w_ext_p0;
        r_skid_mode_p1 <= in_mode;
      end
    end
  end

  assign out_data = r_head_data_p1;
  assign out_mode = r_head_mode_p1;

`ifdef IMM_EXTEND_STATS_EN
  function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] r_xfer_count;
  logic [31:0] r_stall_count;

  // Counters survive flush; only reset clears them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xfer_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop)                  r_xfer_count  <= f_sat_inc(r_xfer_count);
      if (out_valid && !out_ready) r_stall_count <= f_sat_inc(r_stall_count);
    end
  end

  assign xfer_count  = r_xfer_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: queue-based reference model plus literal expectations.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
`ifdef IMM_EXTEND_STATS_EN
  logic [31:0] xfer_count;
  logic [31:0] stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  m;
  } ent_t;
  ent_t q[$];

  imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .BR_SHIFT(2)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
`ifdef IMM_EXTEND_STATS_EN
    ,
    .xfer_count  (xfer_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension from plain integer arithmetic (16 -> 32, shift 2)
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    longint s;
    longint u;
    u = longint'(imm);
    s = (imm >= 16'h8000) ? u - 65536 : u;
    case (mode)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  // Model: bounded FIFO of depth 2
  always @(posedge clk) begin
    bit push;
    bit pop;
    ent_t e;
    push = in_valid && (q.size() < 2);
    pop  = (q.size() != 0) && out_ready;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.d = ref_ext(in_imm, in_mode);
        e.m = in_mode;
        q.push_back(e);
      end
    end
  end

  always @(negedge rst_n) q.delete();

  // Compare process
  always @(negedge clk) begin
    chk("mdl_out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("mdl_in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() != 0) begin
      chk("mdl_out_data", out_data, q[0].d);
      chk("mdl_out_mode", 32'(out_mode), 32'(q[0].m));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_sweep [4];
    exp_sweep[0] = 32'hFFFF8004;
    exp_sweep[1] = 32'h00008004;
    exp_sweep[2] = 32'h80040000;
    exp_sweep[3] = 32'hFFFE0010;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
    #7;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_mode", 32'(out_mode), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #5 rst_n = 1'b1;
    step();

    // Mode sweep
    out_ready = 1'b1; in_valid = 1'b1; in_imm = 16'h8004;
    for (int i = 0; i < 4; i++) begin
      in_mode = 2'(i);
      step();
      chk("sweep_data", out_data, exp_sweep[i]);
      chk("sweep_mode", 32'(out_mode), 32'(i));
      chk("sweep_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("sweep_drain", 32'(out_valid), 32'd0);

    // Back-pressure
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd1; in_imm = 16'h0001;
    step();
    chk("bp_ready1", 32'(in_ready), 32'd1);
    in_imm = 16'h0002;
    step();
    chk("bp_ready2", 32'(in_ready), 32'd0);
    chk("bp_hold_a", out_data, 32'h1);
    in_imm = 16'h0003;
    step();
    chk("bp_hold_b", out_data, 32'h1);
    chk("bp_ready3", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    chk("bp_out2", out_data, 32'h2);
    chk("bp_ready4", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out3", out_data, 32'h3);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Streaming
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_imm = 16'(i * 16'h1111 + 16'h0101); in_mode = 2'(i % 4);
      chk("stream_ready", 32'(in_ready), 32'd1);
      step();
      chk("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain", 32'(out_valid), 32'd0);

    // Flush in TWO with simultaneous push
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_imm = 16'h00AA;
    step();
    in_imm = 16'h00BB;
    step();
    flush = 1'b1; in_imm = 16'h00CC;
    chk("flush_ready_in_cycle", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_two_valid", 32'(out_valid), 32'd0);
    chk("flush_two_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_imm = 16'h00DD; in_mode = 2'd1;
    step();
    in_valid = 1'b0;
    chk("flush_after", out_data, 32'h000000DD);
    step();
    chk("flush_after_drain", 32'(out_valid), 32'd0);

    // Flush in ONE beats a push
    out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h0011; in_mode = 2'd1;
    step();
    flush = 1'b1; in_imm = 16'h0022;
    chk("flush_one_ready", 32'(in_ready), 32'd1);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_one_valid", 32'(out_valid), 32'd0);

    // Async reset mid-stream
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 2'd3;
    for (int i = 0; i < 3; i++) begin
      in_imm = 16'(16'h4000 + i);
      step();
    end
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_mode", 32'(out_mode), 32'd0);
    in_valid = 1'b0;
    #10 rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_imm = 16'h7FFF; in_mode = 2'd0;
    step();
    in_valid = 1'b0;
    chk("arst_resume", out_data, 32'h00007FFF);
    step();

`ifdef IMM_EXTEND_STATS_EN
    rst_n = 1'b0;
    #4 rst_n = 1'b1;
    step();
    chk("st_rst_xfer", xfer_count, 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h0005; in_mode = 2'd1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_imm = 16'(i + 16'h10);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("st_xfer", xfer_count, 32'd5);
    chk("st_stall", stall_count, 32'd3);
    force dut.r_stall_count = 32'hFFFF_FFFE;
    #1 release dut.r_stall_count;
    out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h0001;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("st_stall_sat", stall_count, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    step();
    chk("st_stall_hold", stall_count, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
